// File: rtl/fixedpt_iterative_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// fixedpt_iterative_multiplier_pkg
//   Shared types and width helpers for the iterative shift-add fixed-point
//   multiplier (top: fixedpt_iterative_multiplier, datapath: fixedpt_mul_dpath).
//   Contents:
//     state_e        control FSM states IDLE / CALC / DONE
//     calc_w()       internal datapath width W = n + d
//     cnt_bits()     step counter width, wide enough to hold the value n + d
//   Optional feature macro used by the top level: FPMULIT_EARLY_EXIT_EN
// -----------------------------------------------------------------------------
package fixedpt_iterative_multiplier_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEFAULT_N = 32;
   localparam int DEFAULT_D = 16;

   // Operands are widened to n+d bits so that the full product window
   // needed for the result slice [n+d-1:d] is computed exactly (mod 2^W).
   function automatic int calc_w(input int n, input int d);
      return n + d;
   endfunction

   function automatic int cnt_bits(input int n, input int d);
      return $clog2(n + d + 1);
   endfunction

endpackage

// File: rtl/fixedpt_mul_dpath.sv
// -----------------------------------------------------------------------------
// fixedpt_mul_dpath
//   Shift-add datapath of the iterative fixed-point multiplier. Holds the
//   widened A/B shift registers, the W-bit accumulator, the step counter and
//   the registered result slice. Sequencing comes from the top-level FSM.
//   Parameters: n (operand/result width), d (fractional bits),
//               sign (1 = sign-extend operands, 0 = zero-extend)
//   Ports:
//     clk        in   clock
//     reset      in   synchronous active-low reset
//     load       in   capture a/b (widened), clear accumulator and counter
//     step       in   perform one shift-add step
//     finish     in   register the result slice from this step's sum
//     a, b       in   n-bit operands
//     c          out  n-bit registered result
//     last_step  out  the step taken in this cycle is the final (W-th) one
//     b_drained  out  the multiplier register is zero after this cycle's shift
// -----------------------------------------------------------------------------
module fixedpt_mul_dpath
   import fixedpt_iterative_multiplier_pkg::*;
#(
   parameter int n    = DEFAULT_N,
   parameter int d    = DEFAULT_D,
   parameter int sign = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         step,
   input  logic         finish,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   output logic [n-1:0] c,
   output logic         last_step,
   output logic         b_drained
);

   localparam int W  = calc_w(n, d);
   localparam int CW = cnt_bits(n, d);

   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [n-1:0]  c_q, c_d;

   logic [W-1:0]  a_ext, b_ext;
   logic [W-1:0]  acc_step;
   logic [W-1:0]  b_step;

   // Widen the operands bit by bit: low n bits copied, upper d bits either
   // replicate the operand MSB (signed) or are zero (unsigned).
   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_ext
         if (gi < n) begin : g_lo
            assign a_ext[gi] = a[gi];
            assign b_ext[gi] = b[gi];
         end else begin : g_hi
            assign a_ext[gi] = (sign != 0) && a[n-1];
            assign b_ext[gi] = (sign != 0) && b[n-1];
         end
      end
   endgenerate

   // Sum for the current step; also the source of the result slice so that
   // the final step's addition lands in c on the same edge DONE is entered.
   always_comb begin
      acc_step  = b_q[0] ? (acc_q + a_q) : acc_q;
      b_step    = b_q >> 1;
      last_step = (cnt_q == CW'(W - 1));
      b_drained = (b_step == '0);
   end

   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      c_d   = c_q;
      if (load) begin
         a_d   = a_ext;
         b_d   = b_ext;
         acc_d = '0;
         cnt_d = '0;
      end else if (step) begin
         a_d   = a_q << 1;
         b_d   = b_step;
         acc_d = acc_step;
         cnt_d = cnt_q + CW'(1);
      end
      if (finish) begin
         // Floor rounding: the low d bits are simply dropped.
         c_d = acc_step[W-1:d];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         c_q   <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         c_q   <= c_d;
      end
   end

   assign c = c_q;

endmodule

// File: rtl/fixedpt_iterative_multiplier.sv
// -----------------------------------------------------------------------------
// fixedpt_iterative_multiplier
//   Iterative shift-add fixed-point multiplier: c = (a*b) >> d, truncated to
//   n bits (floor rounding, wrap on overflow). One operation in flight with
//   valid/ready handshakes on request and result sides.
//   Parameters: n (width, default 32), d (fractional bits, default 16),
//               sign (1 = two's complement operands, 0 = unsigned)
//   Ports:
//     clk      in   clock
//     reset    in   synchronous active-low reset (aborts any in-flight op)
//     a, b     in   operands, sampled on accept
//     snd_val  in   request valid
//     snd_rdy  out  ready to accept (IDLE and not in reset)
//     c        out  product, valid while rcv_val=1, held after handoff
//     rcv_val  out  result valid (DONE)
//     rcv_rdy  in   consumer ready
//   Configuration macro:
//     FPMULIT_EARLY_EXIT_EN  when defined, CALC also finishes as soon as the
//                            remaining multiplier bits are all zero
// -----------------------------------------------------------------------------
module fixedpt_iterative_multiplier
   import fixedpt_iterative_multiplier_pkg::*;
#(
   parameter int n    = DEFAULT_N,
   parameter int d    = DEFAULT_D,
   parameter int sign = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         snd_val,
   output logic         snd_rdy,
   output logic [n-1:0] c,
   output logic         rcv_val,
   input  logic         rcv_rdy
);

   state_e state_q, state_d;

   logic load;
   logic step;
   logic finish;
   logic last_step;
   logic b_drained;
   logic calc_end;

`ifdef FPMULIT_EARLY_EXIT_EN
   // Once the remaining multiplier is zero no further additions can occur,
   // so the accumulator already holds the final product.
   assign calc_end = last_step || b_drained;
`else
   assign calc_end = last_step;
   logic unused_b_drained;
   assign unused_b_drained = b_drained;
`endif

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (snd_val) begin
               load    = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            step = 1'b1;
            if (calc_end) begin
               finish  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            // Handoff edge returns to IDLE only; a new request is taken
            // no earlier than the following edge.
            if (rcv_rdy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign snd_rdy = (state_q == IDLE) && reset;
   assign rcv_val = (state_q == DONE);

   fixedpt_mul_dpath #(
      .n    (n),
      .d    (d),
      .sign (sign)
   ) u_dpath (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .step      (step),
      .finish    (finish),
      .a         (a),
      .b         (b),
      .c         (c),
      .last_step (last_step),
      .b_drained (b_drained)
   );

endmodule

// File: tb/tb_fixedpt_iterative_multiplier.sv
// -----------------------------------------------------------------------------
// tb_fixedpt_iterative_multiplier
//   Bench for fixedpt_iterative_multiplier with n=32, d=16. A signed and an
//   unsigned instance share clock, reset, operands and rcv_rdy; each has its
//   own snd_val. Expected products are queued on accept and popped when the
//   result appears.
// -----------------------------------------------------------------------------
module tb_fixedpt_iterative_multiplier;

   localparam int N = 32;
   localparam int D = 16;
   localparam int LAT = N + D;

   logic          clk;
   logic          reset;
   logic [N-1:0]  a_i, b_i;
   logic          snd_val_s, snd_val_u;
   logic          snd_rdy_s, snd_rdy_u;
   logic [N-1:0]  c_s, c_u;
   logic          rcv_val_s, rcv_val_u;
   logic          rcv_rdy;

   bit            uns_sel;
   logic          cur_snd_rdy, cur_rcv_val;
   logic [N-1:0]  cur_c;

   int checks   = 0;
   int failures = 0;
   int op_idx   = 0;

   logic [N-1:0] exp_q[$];

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      bit           uns;
      logic [N-1:0] c;
   } vec_t;

   vec_t vecs[11];

   fixedpt_iterative_multiplier #(.n(N), .d(D), .sign(1)) dut_s (
      .clk     (clk),
      .reset   (reset),
      .a       (a_i),
      .b       (b_i),
      .snd_val (snd_val_s),
      .snd_rdy (snd_rdy_s),
      .c       (c_s),
      .rcv_val (rcv_val_s),
      .rcv_rdy (rcv_rdy)
   );

   fixedpt_iterative_multiplier #(.n(N), .d(D), .sign(0)) dut_u (
      .clk     (clk),
      .reset   (reset),
      .a       (a_i),
      .b       (b_i),
      .snd_val (snd_val_u),
      .snd_rdy (snd_rdy_u),
      .c       (c_u),
      .rcv_val (rcv_val_u),
      .rcv_rdy (rcv_rdy)
   );

   assign cur_snd_rdy = uns_sel ? snd_rdy_u : snd_rdy_s;
   assign cur_rcv_val = uns_sel ? rcv_val_u : rcv_val_s;
   assign cur_c       = uns_sel ? c_u : c_s;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s timeout", name);
   endtask

   // Independent model: full-width product, then take bits [N+D-1:D].
   function automatic logic [N-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input bit uns);
      logic signed [N-1:0] sx, sy;
      longint              p;
      logic [63:0]         up;
      if (uns) begin
         up = {32'b0, x} * {32'b0, y};
      end else begin
         sx = x;
         sy = y;
         p  = longint'(sx) * longint'(sy);
         up = p;
      end
      return up[N+D-1:D];
   endfunction

   // One transaction; hold > 0 keeps rcv_rdy low for that many extra cycles
   // in DONE while a new request is waved at the busy unit.
   task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                         input bit uns, input logic [N-1:0] req, input int hold);
      int           cyc;
      bit           ok;
      logic [N-1:0] exp_c;
      op_idx++;
      @(negedge clk);
      uns_sel = uns;
      rcv_rdy = (hold == 0);
      a_i     = ta;
      b_i     = tb_v;
      if (uns) snd_val_u = 1'b1; else snd_val_s = 1'b1;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         if (cur_snd_rdy) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         fail_now("accept");
         snd_val_s = 1'b0;
         snd_val_u = 1'b0;
         return;
      end
      exp_q.push_back(req);
      @(posedge clk);
      #1;
      snd_val_s = 1'b0;
      snd_val_u = 1'b0;
      cyc = 0;
      ok  = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cur_rcv_val) begin
            ok = 1;
            break;
         end
      end
      exp_c = exp_q.pop_front();
      if (!ok) begin
         fail_now("result");
         return;
      end
`ifdef FPMULIT_EARLY_EXIT_EN
      check("latency_le", 32'(cyc <= LAT), 32'd1);
`else
      check("latency", 32'(cyc), 32'(LAT));
`endif
      check("product", cur_c, exp_c);
      $display("op %0d uns=%0d a=%h b=%h c=%h exp=%h lat=%0d",
               op_idx, uns, ta, tb_v, cur_c, exp_c, cyc);
      for (int h = 0; h < hold; h++) begin
         if (h == 0) begin
            a_i = 32'h1234_5678;
            if (uns) snd_val_u = 1'b1; else snd_val_s = 1'b1;
         end
         @(posedge clk);
         #1;
         check("bp_rcv_val", 32'(cur_rcv_val), 32'd1);
         check("bp_c", cur_c, exp_c);
         check("bp_snd_rdy", 32'(cur_snd_rdy), 32'd0);
      end
      @(negedge clk);
      rcv_rdy = 1'b1;
      if (hold == 0) begin
         snd_val_s = 1'b0;
         snd_val_u = 1'b0;
      end
      @(posedge clk);
      #1;
      // snd_val may still be high here: the handoff edge must not accept.
      check("handoff_rcv_val", 32'(cur_rcv_val), 32'd0);
      check("handoff_snd_rdy", 32'(cur_snd_rdy), 32'd1);
      check("handoff_c_hold", cur_c, exp_c);
      snd_val_s = 1'b0;
      snd_val_u = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{32'h0001_8000, 32'h0002_0000, 1'b0, 32'h0003_0000};
      vecs[1]  = '{32'hFFFE_8000, 32'h0002_0000, 1'b0, 32'hFFFD_0000};
      vecs[2]  = '{32'h0000_8000, 32'h0000_8000, 1'b0, 32'h0000_4000};
      vecs[3]  = '{32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0000};
      vecs[4]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF};
      vecs[5]  = '{32'hFFFF_0000, 32'h0002_0000, 1'b1, 32'hFFFE_0000};
      vecs[6]  = '{32'hFFFE_8000, 32'hFFFE_0000, 1'b0, 32'h0003_0000};
      vecs[7]  = '{32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0000_0000};
      vecs[8]  = '{32'h7FFF_0000, 32'h0004_0000, 1'b0, 32'hFFFC_0000};
      vecs[9]  = '{32'h0001_0000, 32'h8000_0000, 1'b0, 32'h8000_0000};
      vecs[10] = '{32'h8000_0000, 32'h0001_0000, 1'b1, 32'h8000_0000};

      reset     = 1'b0;
      a_i       = '0;
      b_i       = '0;
      snd_val_s = 1'b0;
      snd_val_u = 1'b0;
      rcv_rdy   = 1'b1;
      uns_sel   = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_snd_rdy_low", 32'(snd_rdy_s), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_snd_rdy_s", 32'(snd_rdy_s), 32'd1);
      check("rst_rcv_val_s", 32'(rcv_val_s), 32'd0);
      check("rst_c_s", c_s, 32'd0);
      check("rst_snd_rdy_u", 32'(snd_rdy_u), 32'd1);
      check("rst_c_u", c_u, 32'd0);

      // Directed table.
      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].uns, vecs[i].c, 0);
      end

      // Random operands against the full-width model.
      for (int i = 0; i < 8; i++) begin
         logic [N-1:0] ra, rb;
         bit           ru;
         ra = $urandom;
         rb = $urandom;
         ru = (i % 3 == 2);
         run_op(ra, rb, ru, model(ra, rb, ru), 0);
      end

      // Back-pressure: result held 5 extra cycles with a competing request.
      run_op(32'h0001_8000, 32'h0002_0000, 1'b0, 32'h0003_0000, 5);
      run_op(32'h0000_8000, 32'h0000_8000, 1'b0, 32'h0000_4000, 0);

      // Reset mid-calculation: the in-flight op must vanish.
      @(negedge clk);
      uns_sel   = 1'b0;
      a_i       = 32'h0003_0000;
      b_i       = 32'h0003_0000;
      snd_val_s = 1'b1;
      check("abort_accept_rdy", 32'(snd_rdy_s), 32'd1);
      @(posedge clk);
      #1;
      snd_val_s = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("abort_in_reset_rdy", 32'(snd_rdy_s), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_snd_rdy", 32'(snd_rdy_s), 32'd1);
      check("abort_rcv_val", 32'(rcv_val_s), 32'd0);
      check("abort_c", c_s, 32'd0);
      $display("op abort: reset during CALC, snd_rdy=%0d rcv_val=%0d c=%h",
               snd_rdy_s, rcv_val_s, c_s);
      run_op(32'hFFFE_8000, 32'h0002_0000, 1'b0, 32'hFFFD_0000, 0);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
